// File: rtl/pipelined_subtractor_if.sv
// Stream interface for pipelined_subtractor: operand channel in, result channel out.
interface pipelined_subtractor_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] X;
  logic [15:0] Y;
  logic        B_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] D;
  logic        B_out;
  logic        V;
  logic        Z;
  logic        N;

  modport master (
    output in_valid, X, Y, B_in, out_ready,
    input  in_ready, out_valid, D, B_out, V, Z, N
  );

  modport slave (
    input  in_valid, X, Y, B_in, out_ready,
    output in_ready, out_valid, D, B_out, V, Z, N
  );
endinterface

// File: rtl/pipelined_subtractor.sv
// Two-stage 16-bit subtractor D = X - Y - B_in with valid/ready handshake and status flags.
// Optional SUB_SATURATE_EN: clamp D to 0x8000/0x7FFF on signed overflow.
module pipelined_subtractor (
  input  logic                   clk,
  input  logic                   rst,
  pipelined_subtractor_if.slave  bus
);

  logic        v1, v2;
  logic [7:0]  lo1, xh1, nyh1;
  logic        c8_1, x15_1, y15_1;
  logic [15:0] d_q;
  logic        b_q, ov_q, z_q, n_q;

  logic        stage1_adv, stage2_adv, in_xfer;
  logic [8:0]  lo_sum, hi_sum;
  logic [15:0] raw_d, d_next;
  logic        ov_next;

  assign stage2_adv = !v2 || bus.out_ready;
  assign stage1_adv = !v1 || stage2_adv;
  assign in_xfer    = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = stage1_adv && !rst;
  assign bus.out_valid = v2;
  assign bus.D         = d_q;
  assign bus.B_out     = b_q;
  assign bus.V         = ov_q;
  assign bus.Z         = z_q;
  assign bus.N         = n_q;

  // Subtraction as X + ~Y + ~B_in; the final carry is the inverted borrow.
  always_comb begin
    lo_sum  = {1'b0, bus.X[7:0]} + {1'b0, ~bus.Y[7:0]} + {8'd0, ~bus.B_in};
    hi_sum  = {1'b0, xh1} + {1'b0, nyh1} + {8'd0, c8_1};
    raw_d   = {hi_sum[7:0], lo1};
    ov_next = (x15_1 ^ y15_1) & (x15_1 ^ raw_d[15]);
`ifdef SUB_SATURATE_EN
    if (ov_next)
      d_next = x15_1 ? 16'h8000 : 16'h7FFF;
    else
      d_next = raw_d;
`else
    d_next = raw_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      lo1   <= '0;
      xh1   <= '0;
      nyh1  <= '0;
      c8_1  <= 1'b0;
      x15_1 <= 1'b0;
      y15_1 <= 1'b0;
      d_q   <= '0;
      b_q   <= 1'b0;
      ov_q  <= 1'b0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else begin
      if (stage1_adv) begin
        v1 <= in_xfer;
        if (in_xfer) begin
          lo1   <= lo_sum[7:0];
          c8_1  <= lo_sum[8];
          xh1   <= bus.X[15:8];
          nyh1  <= ~bus.Y[15:8];
          x15_1 <= bus.X[15];
          y15_1 <= bus.Y[15];
        end
      end
      // Data registers only load on a real transfer so an emptied stage holds its last value.
      if (stage2_adv) begin
        v2 <= v1;
        if (v1) begin
          d_q  <= d_next;
          b_q  <= !hi_sum[8];
          ov_q <= ov_next;
          z_q  <= (d_next == 16'h0000);
          n_q  <= d_next[15];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed self-checking bench for pipelined_subtractor (both SUB_SATURATE_EN builds).
module tb_pipelined_subtractor;

  logic clk;
  logic rst;
  int unsigned n_assert;
  int unsigned n_fail;

  pipelined_subtractor_if bus ();

  pipelined_subtractor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic b, input logic [15:0] exp_d, input logic exp_b,
                        input logic exp_v, input logic exp_z, input logic exp_n);
    bus.out_ready = 1'b1;
    bus.X         = x;
    bus.Y         = y;
    bus.B_in      = b;
    bus.in_valid  = 1'b1;
    chk({tag, "_in_ready"}, {15'd0, bus.in_ready}, 16'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, {15'd0, bus.out_valid}, 16'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, {15'd0, bus.out_valid}, 16'd1);
    chk({tag, "_D"}, bus.D, exp_d);
    chk({tag, "_B"}, {15'd0, bus.B_out}, {15'd0, exp_b});
    chk({tag, "_V"}, {15'd0, bus.V}, {15'd0, exp_v});
    chk({tag, "_Z"}, {15'd0, bus.Z}, {15'd0, exp_z});
    chk({tag, "_N"}, {15'd0, bus.N}, {15'd0, exp_n});
  endtask

  logic [15:0] sx   [5];
  logic [15:0] sy   [5];
  logic        sb   [5];
  logic [15:0] sexp [5];

  initial begin
    int unsigned sent, recv, cyc;
    logic        stalled_prev;
    logic [15:0] held_d;

    n_assert = 0;
    n_fail   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.X         = '0;
    bus.Y         = '0;
    bus.B_in      = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
    chk("rst_D", bus.D, 16'h0000);
    chk("rst_flags", {12'd0, bus.B_out, bus.V, bus.Z, bus.N}, 16'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {15'd0, bus.in_ready}, 16'd1);

    // Single operations
    run_op("sub5_3",   16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub0_1",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    run_op("subeq",    16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op("bytecarry",16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SUB_SATURATE_EN
    run_op("ovf_neg",  16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    run_op("ovf_neg",  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("ovf_pos",  16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
    @(posedge clk); #1;
    chk("drain_empty", {15'd0, bus.out_valid}, 16'd0);

    // Back-pressure stream: out_ready low for cycles 2..4
    sx[0] = 16'h1000; sy[0] = 16'h0001; sb[0] = 1'b0; sexp[0] = 16'h0FFF;
    sx[1] = 16'h0003; sy[1] = 16'h0005; sb[1] = 1'b0; sexp[1] = 16'hFFFE;
    sx[2] = 16'hABCD; sy[2] = 16'h1234; sb[2] = 1'b0; sexp[2] = 16'h9999;
    sx[3] = 16'h0050; sy[3] = 16'h0020; sb[3] = 1'b1; sexp[3] = 16'h002F;
    sx[4] = 16'hFFFF; sy[4] = 16'hFFFF; sb[4] = 1'b0; sexp[4] = 16'h0000;
    sent = 0;
    recv = 0;
    stalled_prev = 1'b0;
    held_d = '0;
    for (cyc = 0; cyc < 30 && recv < 5; cyc++) begin
      bus.out_ready = !(cyc >= 2 && cyc <= 4);
      bus.in_valid  = (sent < 5);
      if (sent < 5) begin
        bus.X    = sx[sent];
        bus.Y    = sy[sent];
        bus.B_in = sb[sent];
      end
      #1;
      if (stalled_prev) begin
        chk("bp_hold_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("bp_hold_D", bus.D, held_d);
      end
      chk("bp_in_ready", {15'd0, bus.in_ready},
          {15'd0, !((sent - recv) == 2 && !bus.out_ready)});
      stalled_prev = bus.out_valid && !bus.out_ready;
      held_d       = bus.D;
      if (bus.out_valid && bus.out_ready) begin
        chk("bp_order_D", bus.D, sexp[recv]);
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("bp_all_received", recv[15:0], 16'd5);

    // Reset with two results in flight
    bus.out_ready = 1'b0;
    bus.X = 16'h0009; bus.Y = 16'h0002; bus.B_in = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.X = 16'h0010; bus.Y = 16'h0001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mid_full_in_ready", {15'd0, bus.in_ready}, 16'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", {15'd0, bus.in_ready}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("mid_rst_in_ready_after", {15'd0, bus.in_ready}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("no_stale", {15'd0, bus.out_valid}, 16'd0);
    end
    run_op("after_rst", 16'h0009, 16'h0002, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
